// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler driving the shared per-lane execution units.
// Optional perf counters (perf_issued, perf_stall) are built when ISSUE_PERF_CNT_EN is defined.
module warp_issue_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_LANES   = 8,
    parameter int WARP_ID_W   = 2,
    parameter int MEM_LATENCY = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WARPS-1:0]           warp_req,
    input  logic [NUM_WARPS*NUM_LANES-1:0] warp_mask,
    input  logic [NUM_WARPS*5-1:0]         warp_op,
    input  logic [NUM_WARPS-1:0]           warp_is_mem,
    input  logic [NUM_WARPS-1:0]           warp_mem_wr,
    input  logic                           stall,
    output logic [NUM_WARPS-1:0]           grant,
    output logic                           issue_valid,
    output logic [WARP_ID_W-1:0]           issue_warp,
    output logic [NUM_LANES-1:0]           enable_vector,
    output logic [4:0]                     alu_op,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic                           busy
`ifdef ISSUE_PERF_CNT_EN
   ,output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_stall
`endif
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, MEM_WAIT} state_t;

    state_t               state, state_n;
    logic [WARP_ID_W-1:0] rr_ptr;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 mem_first;
    logic                 arb;
    logic                 found;
    logic [WARP_ID_W-1:0] win, idx, rr_next;
    logic [NUM_LANES-1:0] win_mask;
    logic [4:0]           win_op;
    logic                 live, win_mem, win_wr;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = WARP_ID_W'((int'(rr_ptr) + k) % NUM_WARPS);
            if (!found && warp_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_mask = warp_mask[win*NUM_LANES +: NUM_LANES];
    assign win_op   = warp_op[win*5 +: 5];
    assign live     = found && (|win_mask);
    assign win_mem  = warp_is_mem[win];
    assign win_wr   = warp_mem_wr[win];
    assign rr_next  = (win == WARP_ID_W'(NUM_WARPS - 1)) ? '0 : win + 1'b1;

    // The issue cycle of a memory op is not one of the MEM_LATENCY extra cycles;
    // mem_first marks it so the countdown starts one cycle later.
    always_comb begin
        state_n = state;
        arb     = 1'b0;
        if (!stall) begin
            case (state)
                IDLE, ISSUE: arb = 1'b1;
                MEM_WAIT:    arb = !mem_first && (wait_cnt == CNT_W'(1));
                default:     state_n = IDLE;
            endcase
        end
        if (arb) begin
            if (!found)                state_n = IDLE;
            else if (live && win_mem)  state_n = MEM_WAIT;
            else                       state_n = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant         <= '0;
            issue_valid   <= 1'b0;
            issue_warp    <= '0;
            enable_vector <= '0;
            alu_op        <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            busy          <= 1'b0;
            rr_ptr        <= '0;
            wait_cnt      <= '0;
            mem_first     <= 1'b0;
        end else if (stall) begin
            grant <= '0;
        end else if (arb) begin
            grant         <= found ? (NUM_WARPS'(1) << win) : '0;
            issue_valid   <= live;
            enable_vector <= live ? win_mask : '0;
            mem_read      <= live & win_mem & ~win_wr;
            mem_write     <= live & win_mem & win_wr;
            busy          <= live & win_mem;
            mem_first     <= live & win_mem;
            wait_cnt      <= (live && win_mem) ? CNT_W'(MEM_LATENCY) : '0;
            if (found) rr_ptr <= rr_next;
            // A zero-mask grant only consumes the instruction; the datapath keeps its last op.
            if (live) begin
                issue_warp <= win;
                alu_op     <= win_op;
            end
        end else begin
            grant <= '0;
            if (mem_first) mem_first <= 1'b0;
            else           wait_cnt  <= wait_cnt - 1'b1;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (arb && live) perf_issued <= perf_issued + 32'd1;
            if (stall && ((|warp_req) || state == MEM_WAIT)) perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Scoreboard bench for warp_issue_scheduler: stimulus queues expected outputs, a monitor compares.
module tb_warp_issue_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  warp_req;
    logic [31:0] warp_mask;
    logic [19:0] warp_op;
    logic [3:0]  warp_is_mem;
    logic [3:0]  warp_mem_wr;
    logic        stall;
    logic [3:0]  grant;
    logic        issue_valid;
    logic [1:0]  issue_warp;
    logic [7:0]  enable_vector;
    logic [4:0]  alu_op;
    logic        mem_read, mem_write, busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    warp_issue_scheduler #(.NUM_WARPS(4), .NUM_LANES(8), .WARP_ID_W(2), .MEM_LATENCY(3)) dut (
        .clk(clk), .reset(reset), .warp_req(warp_req), .warp_mask(warp_mask), .warp_op(warp_op),
        .warp_is_mem(warp_is_mem), .warp_mem_wr(warp_mem_wr), .stall(stall), .grant(grant),
        .issue_valid(issue_valid), .issue_warp(issue_warp), .enable_vector(enable_vector),
        .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .busy(busy)
`ifdef ISSUE_PERF_CNT_EN
       ,.perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [22:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [22:0] ev(logic [3:0] g, logic v, logic [1:0] w, logic [7:0] en,
                                       logic [4:0] op, logic rd, logic wr, logic b);
        return {g, v, w, en, op, rd, wr, b};
    endfunction

    function automatic logic [22:0] act();
        return {grant, issue_valid, issue_warp, enable_vector, alu_op, mem_read, mem_write, busy};
    endfunction

    task automatic chk(input string nm, input logic [22:0] a, input logic [22:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got g=%b v=%b w=%0d en=%h op=%0d rd=%b wr=%b busy=%b, expected g=%b v=%b w=%0d en=%h op=%0d rd=%b wr=%b busy=%b",
                     nm, a[22:19], a[18], a[17:16], a[15:8], a[7:3], a[2], a[1], a[0],
                     e[22:19], e[18], e[17:16], e[15:8], e[7:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic set_warp(input int i, input logic [7:0] m, input logic [4:0] op,
                            input logic is_mem, input logic wr);
        warp_mask[i*8 +: 8] = m;
        warp_op[i*5 +: 5]   = op;
        warp_is_mem[i]      = is_mem;
        warp_mem_wr[i]      = wr;
    endtask

    // Called at a negedge: drive req/stall for the next posedge, queue what must follow it.
    task automatic cyc(input string nm, input logic [3:0] req, input logic stl, input logic [22:0] e);
        exp_t x;
        warp_req = req;
        stall    = stl;
        x.name   = nm;
        x.v      = e;
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.name, act(), x.v);
            end
        end
    end

    initial begin
        reset = 1'b0; warp_req = '0; warp_mask = '0; warp_op = '0;
        warp_is_mem = '0; warp_mem_wr = '0; stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", act(), '0);
        reset = 1'b1;

        // all four requesting: strict rotation starting at warp 0
        for (int i = 0; i < 4; i++) set_warp(i, 8'hFF, 5'(i + 1), 1'b0, 1'b0);
        cyc("rr_g0", 4'b1111, 0, ev(4'b0001, 1, 0, 8'hFF, 5'd1, 0, 0, 0));
        cyc("rr_g1", 4'b1111, 0, ev(4'b0010, 1, 1, 8'hFF, 5'd2, 0, 0, 0));
        cyc("rr_g2", 4'b1111, 0, ev(4'b0100, 1, 2, 8'hFF, 5'd3, 0, 0, 0));
        cyc("rr_g3", 4'b1111, 0, ev(4'b1000, 1, 3, 8'hFF, 5'd4, 0, 0, 0));
        cyc("rr_g0b", 4'b1111, 0, ev(4'b0001, 1, 0, 8'hFF, 5'd1, 0, 0, 0));
        cyc("idle1", 4'b0000, 0, ev(4'b0000, 0, 0, 8'h00, 5'd1, 0, 0, 0));

        // single warp 2
        set_warp(2, 8'h3C, 5'd7, 1'b0, 1'b0);
        cyc("single_w2", 4'b0100, 0, ev(4'b0100, 1, 2, 8'h3C, 5'd7, 0, 0, 0));
        cyc("idle2", 4'b0000, 0, ev(4'b0000, 0, 2, 8'h00, 5'd7, 0, 0, 0));

        // warp 1 memory read while warp 2 waits
        set_warp(1, 8'h0F, 5'd9, 1'b1, 1'b0);
        cyc("mem_issue", 4'b0110, 0, ev(4'b0010, 1, 1, 8'h0F, 5'd9, 1, 0, 1));
        cyc("mem_wait1", 4'b0110, 0, ev(4'b0000, 1, 1, 8'h0F, 5'd9, 1, 0, 1));
        cyc("mem_wait2", 4'b0110, 0, ev(4'b0000, 1, 1, 8'h0F, 5'd9, 1, 0, 1));
        cyc("mem_wait3", 4'b0110, 0, ev(4'b0000, 1, 1, 8'h0F, 5'd9, 1, 0, 1));
        cyc("after_mem_w2", 4'b0110, 0, ev(4'b0100, 1, 2, 8'h3C, 5'd7, 0, 0, 0));
        cyc("idle3", 4'b0000, 0, ev(4'b0000, 0, 2, 8'h00, 5'd7, 0, 0, 0));

        // zero-mask warp 0: consumed, nothing issued, pointer moves to 1
        set_warp(0, 8'h00, 5'd1, 1'b0, 1'b0);
        cyc("zero_mask", 4'b0001, 0, ev(4'b0001, 0, 2, 8'h00, 5'd7, 0, 0, 0));
        set_warp(0, 8'hFF, 5'd1, 1'b0, 1'b0);
        set_warp(1, 8'hFF, 5'd2, 1'b0, 1'b0);
        cyc("ptr_after_zero", 4'b0011, 0, ev(4'b0010, 1, 1, 8'hFF, 5'd2, 0, 0, 0));
        cyc("idle4", 4'b0000, 0, ev(4'b0000, 0, 1, 8'h00, 5'd2, 0, 0, 0));

        // memory write, then stall held 5 cycles in the middle of the wait
        set_warp(0, 8'hA5, 5'd12, 1'b1, 1'b1);
        cyc("memwr_issue", 4'b0001, 0, ev(4'b0001, 1, 0, 8'hA5, 5'd12, 0, 1, 1));
        cyc("memwr_w1", 4'b0000, 0, ev(4'b0000, 1, 0, 8'hA5, 5'd12, 0, 1, 1));
        cyc("memwr_w2", 4'b0000, 0, ev(4'b0000, 1, 0, 8'hA5, 5'd12, 0, 1, 1));
        for (int i = 0; i < 5; i++)
            cyc("stall_frozen", 4'b0000, 1, ev(4'b0000, 1, 0, 8'hA5, 5'd12, 0, 1, 1));
        cyc("memwr_w3", 4'b0000, 0, ev(4'b0000, 1, 0, 8'hA5, 5'd12, 0, 1, 1));
        cyc("memwr_done", 4'b0000, 0, ev(4'b0000, 0, 0, 8'h00, 5'd12, 0, 0, 0));

        // request arriving under stall is held off, then granted on first free edge
        cyc("stall_idle1", 4'b0100, 1, ev(4'b0000, 0, 0, 8'h00, 5'd12, 0, 0, 0));
        cyc("stall_idle2", 4'b0100, 1, ev(4'b0000, 0, 0, 8'h00, 5'd12, 0, 0, 0));
        cyc("unstall_w2", 4'b0100, 0, ev(4'b0100, 1, 2, 8'h3C, 5'd7, 0, 0, 0));

        // reset in the middle of a memory wait
        set_warp(3, 8'hFF, 5'd20, 1'b1, 1'b0);
        cyc("mem3_issue", 4'b1000, 0, ev(4'b1000, 1, 3, 8'hFF, 5'd20, 1, 0, 1));
        cyc("mem3_wait", 4'b0000, 0, ev(4'b0000, 1, 3, 8'hFF, 5'd20, 1, 0, 1));
        #2 reset = 1'b0;
        #1 chk("async_reset", act(), '0);
        @(negedge clk);
        reset = 1'b1;
        set_warp(0, 8'hFF, 5'd1, 1'b0, 1'b0);
        cyc("post_reset_w0", 4'b0101, 0, ev(4'b0001, 1, 0, 8'hFF, 5'd1, 0, 0, 0));
        cyc("post_reset_w2", 4'b0101, 0, ev(4'b0100, 1, 2, 8'h3C, 5'd7, 0, 0, 0));
        cyc("idle_end", 4'b0000, 0, ev(4'b0000, 0, 2, 8'h00, 5'd7, 0, 0, 0));

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end
endmodule
